fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the PC and branch-target width.
REQ-002 SHALL have parameter NUM_INST, default 17, giving the instruction ROM depth in words.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, giving the cycles from PC change to a valid opcode at the memory outputs.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low (0 = reset).
REQ-006 start  input  1  begin execution from PC 0; sampled in IDLE and HALT only.
REQ-007 stall  input  1  hold the current instruction; honoured in EXEC only.
REQ-008 branch_taken  input  1  redirect the next PC to branch_target; sampled in EXEC only.
REQ-009 branch_target  input  WIDTH  byte address of the redirect.
REQ-010 opcode  input  7  opcode returned by the instruction memory for the current PC.
REQ-011 pc  output  WIDTH  byte address presented to the instruction memory.
REQ-012 inst_valid  output  1  opcode and fields for pc are valid this cycle.
REQ-013 busy  output  1  high in FETCH or EXEC.
REQ-014 halted  output  1  high in HALT.
REQ-015 inst_count  output  16  count of retired instructions.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, EXEC and HALT; all outputs SHALL be registered or decoded from state only.
REQ-017 IDLE: pc=0, inst_valid=0; start=1 -> FETCH with latency counter=0.
REQ-018 FETCH: latency counter SHALL increment each cycle; at counter==MEM_LATENCY-1 -> EXEC, so EXEC begins exactly MEM_LATENCY cycles after FETCH entry; pc SHALL be stable throughout.
REQ-019 EXEC: inst_valid=1 for every cycle in state.
REQ-020 EXEC with opcode==7'b0 (NO-OP terminator) -> HALT; SHALL take priority over stall and branch_taken; SHALL NOT increment inst_count.
REQ-021 EXEC with stall=1 and opcode!=0: remain in EXEC; pc and inst_count unchanged; branch_taken ignored.
REQ-022 EXEC with stall=0 and opcode!=0: inst_count+1; next pc = branch_taken ? {branch_target[WIDTH-1:2],2'b00} : pc+4.
REQ-023 If next pc/4 >= NUM_INST -> HALT and pc holds the last fetched value; otherwise -> FETCH with the new pc and latency counter=0.
REQ-024 inst_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-025 HALT: inst_valid=0 and pc held; start=1 -> FETCH with pc=0 and inst_count=0.
REQ-026 start SHALL be ignored in FETCH and EXEC; stall and branch_taken SHALL be ignored outside EXEC.
REQ-027 A branch to the current pc SHALL re-fetch with full MEM_LATENCY; no fetch short-cut is permitted.

Reset
REQ-028 With rst=0 at a clk edge, the next state SHALL be IDLE, with pc=0, inst_valid=0, busy=0, halted=0, inst_count=0 and latency counter=0, regardless of the current state.
REQ-029 Reset in FETCH or EXEC SHALL abort the instruction in flight without incrementing inst_count.
REQ-030 The first cycle after rst returns to 1 SHALL be IDLE; a start sampled in that cycle SHALL be honoured.

Structure
REQ-031 A shared package riscv_pkg SHALL hold: the state enum, OPCODE_NOP=7'b0000000, OPCODE_BRANCH=7'b1100011, OPCODE_LOAD=7'b0000011, OPCODE_STORE=7'b0100011, and the defaults for NUM_INST and MEM_LATENCY.
REQ-032 No sub-module is required; the FSM, latency counter and PC adder SHALL live in fetch_sequencer.

Verification
REQ-033 Reset then start pulse, opcodes nonzero, no stall -> pc steps 0,4,8,... with each step 3 cycles apart (MEM_LATENCY=2 plus 1 EXEC); HALT after pc=64; inst_count=17.
REQ-034 opcode=0 returned at pc=12 -> HALT, halted=1, inst_count=3, pc stays 12.
REQ-035 stall held 4 cycles in EXEC at pc=8 -> inst_valid high 5 cycles, pc=8 throughout, then pc=12.
REQ-036 branch_taken=1 with branch_target=32'h22 in EXEC at pc=4 -> next pc=32'h20; with stall=1 in the same cycle, the branch is ignored.
REQ-037 rst=0 asserted mid-FETCH at pc=20 -> next cycle in IDLE with pc=0, inst_count=0, inst_valid=0; a following start restarts at pc 0.
REQ-038 start asserted in HALT after a run -> pc=0, inst_count=0, re-execution identical to REQ-033.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path: sequencer states,
// the opcodes the front end recognises, and default ROM/memory geometry.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [6:0] OPCODE_NOP    = 7'b0000000;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;

  localparam int DEFAULT_NUM_INST    = 17;
  localparam int DEFAULT_MEM_LATENCY = 2;

  localparam logic [15:0] INST_COUNT_MAX = 16'hFFFF;

  // Retired-instruction counter step that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == INST_COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: presents a PC to a fixed-latency instruction ROM,
// waits for the opcode, then retires, stalls, branches or halts on it.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_INST    = DEFAULT_NUM_INST,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [6:0]       opcode,
  output logic [WIDTH-1:0] pc,
  output logic             inst_valid,
  output logic             busy,
  output logic             halted,
  output logic [15:0]      inst_count,
  output logic [1:0]       o_dbg_state
);

  localparam int               CNT_W      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] PC_LIMIT   = WIDTH'(NUM_INST);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pc_redirect;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [CNT_W-1:0] w_lat_cnt_nxt;
  logic [15:0]      r_inst_count;
  logic [15:0]      w_inst_count_nxt;
  logic             w_past_rom;

  // Candidate PC for the instruction after the one in EXEC; word aligned.
  assign w_pc_redirect = branch_taken ? (branch_target & ALIGN_MASK) : (r_pc + PC_STEP);
  assign w_past_rom    = ((w_pc_redirect >> 2) >= PC_LIMIT);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_lat_cnt_nxt    = r_lat_cnt;
    w_inst_count_nxt = r_inst_count;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_FETCH;
          w_pc_nxt      = '0;
          w_lat_cnt_nxt = '0;
        end
      end
      ST_FETCH: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt   = ST_EXEC;
          w_lat_cnt_nxt = '0;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        // A NOP opcode terminates the program before stall or branch are looked at.
        if (opcode == OPCODE_NOP) begin
          w_state_nxt = ST_HALT;
        end else if (!stall) begin
          w_inst_count_nxt = sat_inc16(r_inst_count);
          if (w_past_rom) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt   = ST_FETCH;
            w_pc_nxt      = w_pc_redirect;
            w_lat_cnt_nxt = '0;
          end
        end
      end
      ST_HALT: begin
        if (start) begin
          w_state_nxt      = ST_FETCH;
          w_pc_nxt         = '0;
          w_lat_cnt_nxt    = '0;
          w_inst_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_lat_cnt    <= '0;
      r_inst_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_lat_cnt    <= w_lat_cnt_nxt;
      r_inst_count <= w_inst_count_nxt;
    end
  end

  assign pc          = r_pc;
  assign inst_count  = r_inst_count;
  assign inst_valid  = (r_state == ST_EXEC);
  assign busy        = (r_state == ST_FETCH) || (r_state == ST_EXEC);
  assign halted      = (r_state == ST_HALT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written multi-cycle
// scenarios, and random programs checked against an instruction-level schedule.
module tb_fetch_sequencer;
  import riscv_pkg::*;

  localparam int WIDTH    = 32;
  localparam int NUM_INST = 17;
  localparam int LAT      = 2;
  localparam int MAXC     = 256;
  localparam int TAIL     = 4;
  localparam int NRUNS    = 12;

  localparam logic [2:0] FL_I = 3'b000;  // {inst_valid, busy, halted}
  localparam logic [2:0] FL_F = 3'b010;
  localparam logic [2:0] FL_E = 3'b110;
  localparam logic [2:0] FL_H = 3'b001;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             branch_taken = 1'b0;
  logic [WIDTH-1:0] branch_target = '0;
  logic [6:0]       opcode;
  logic [6:0]       opcode_drv = 7'h13;
  logic             use_rom = 1'b0;
  logic [6:0]       rom [NUM_INST];
  logic [6:0]       rom_word;

  wire [WIDTH-1:0] pc;
  wire             inst_valid;
  wire             busy;
  wire             halted;
  wire [15:0]      inst_count;
  wire [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.WIDTH(WIDTH), .NUM_INST(NUM_INST), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .opcode(opcode),
    .pc(pc), .inst_valid(inst_valid), .busy(busy), .halted(halted),
    .inst_count(inst_count), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Instruction ROM behind the DUT's pc, or a directly driven opcode.
  always_comb begin
    rom_word = 7'h13;
    if ((pc >> 2) < NUM_INST) rom_word = rom[pc >> 2];
  end
  assign opcode = use_rom ? rom_word : opcode_drv;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic fill_rom(input bit allow_nop);
    for (int i = 0; i < NUM_INST; i++) begin
      rom[i] = 7'($urandom_range(1, 127));
      if (allow_nop && $urandom_range(0, 15) == 0) rom[i] = OPCODE_NOP;
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] fl_to_state(input logic [2:0] fl);
    case (fl)
      FL_H:    return ST_HALT;
      FL_E:    return ST_EXEC;
      FL_F:    return ST_FETCH;
      default: return ST_IDLE;
    endcase
  endfunction

  task automatic check_obs(input string tag, input logic [31:0] e_pc_v,
                           input logic [2:0] e_fl_v, input logic [15:0] e_cnt_v);
    check({tag, "_pc"}, pc, e_pc_v);
    check({tag, "_flags"}, 32'({inst_valid, busy, halted}), 32'(e_fl_v));
    check({tag, "_cnt"}, 32'(inst_count), 32'(e_cnt_v));
  endtask

  // Directed vector table: inputs applied before an edge, outputs expected after it.
  typedef struct packed {
    logic        rst;
    logic        start;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [2:0]  fl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic r, input logic s, input logic st, input logic b,
                               input logic [31:0] t, input logic [6:0] o,
                               input logic [31:0] p, input logic [2:0] f, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.start = s; v.stall = st; v.br = b; v.tgt = t; v.op = o;
    v.pc = p; v.fl = f; v.cnt = c;
    vecs.push_back(v);
  endfunction

  // Random-program schedule, built one instruction at a time.
  logic        in_start [MAXC];
  logic        in_stall [MAXC];
  logic        in_br    [MAXC];
  logic [31:0] in_tgt   [MAXC];
  logic [31:0] e_pc     [MAXC];
  logic [2:0]  e_fl     [MAXC];
  logic [15:0] e_cnt    [MAXC];

  function automatic void set_exp(input int c, input logic [31:0] p, input logic [2:0] f,
                                  input logic [15:0] k);
    e_pc[c] = p; e_fl[c] = f; e_cnt[c] = k;
  endfunction

  // Each instruction costs LAT fetch cycles plus 1+stalls exec cycles; a NOP
  // halts on its first exec cycle; leaving the ROM halts with pc held.
  task automatic build_run(output int ncyc);
    int          c, s, n, h;
    logic [31:0] p, nxt;
    logic [15:0] k;
    bit          done;
    for (int i = 0; i < MAXC; i++) begin
      in_start[i] = 1'b0;
      in_stall[i] = 1'($urandom_range(0, 1));
      in_br[i]    = 1'($urandom_range(0, 1));
      in_tgt[i]   = $urandom;
    end
    in_start[0] = 1'b1;
    p = 0; k = 0; c = 0; h = 0; done = 0;
    while (!done) begin
      for (int i = 0; i < LAT; i++) set_exp(c + i, p, FL_F, k);
      s = c + LAT;
      if (rom[p >> 2] == OPCODE_NOP) begin
        set_exp(s, p, FL_E, k);
        h = s + 1;
        done = 1;
      end else begin
        n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        for (int j = 0; j <= n; j++) begin
          set_exp(s + j, p, FL_E, k);
          in_stall[s + j + 1] = (j < n);
        end
        k = k + 16'd1;
        in_br[s + n + 1] = ($urandom_range(0, 3) == 0);
        if (in_br[s + n + 1]) begin
          nxt = p + 32'(4 * $urandom_range(1, 8));
          in_tgt[s + n + 1] = nxt + 32'($urandom_range(0, 3));
        end else begin
          nxt = p + 32'd4;
        end
        if ((nxt >> 2) >= NUM_INST) begin
          h = s + n + 1;
          done = 1;
        end else begin
          p = nxt;
          c = s + n + 1;
        end
      end
    end
    for (int t = h; t < h + TAIL; t++) set_exp(t, p, FL_H, k);
    for (int i = 1; i <= h; i++) in_start[i] = 1'($urandom_range(0, 1));
    ncyc = h + TAIL;
  endtask

  task automatic run_linear(input string tag);
    logic [WIDTH-1:0] exp_q[$];
    for (int k = 0; k < NUM_INST; k++) exp_q.push_back(WIDTH'(4 * k));
    stall = 1'b0; branch_taken = 1'b0;
    for (int k = 0; k < NUM_INST; k++) begin
      for (int i = 0; i < LAT; i++) begin
        start = (k == 0 && i == 0);
        tick();
        check_obs($sformatf("%s_fetch%0d_%0d", tag, k, i), exp_q[0], FL_F, 16'(k));
      end
      start = 1'b0;
      tick();
      check_obs($sformatf("%s_exec%0d", tag, k), exp_q.pop_front(), FL_E, 16'(k));
    end
    tick();
    check_obs({tag, "_halt"}, 32'd64, FL_H, 16'd17);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : main
    int ncyc;
    int n;
    int vcnt;

    // Directed table
    addv(0, 0, 0, 0, 32'h0,  7'h05, 32'h0,  FL_I, 16'd0);
    addv(1, 0, 1, 1, 32'h40, 7'h05, 32'h0,  FL_I, 16'd0);
    addv(1, 1, 0, 0, 32'h0,  7'h05, 32'h0,  FL_F, 16'd0);
    addv(1, 1, 0, 0, 32'h0,  7'h05, 32'h0,  FL_F, 16'd0);
    addv(1, 0, 0, 0, 32'h0,  7'h05, 32'h0,  FL_E, 16'd0);
    addv(1, 0, 1, 1, 32'h22, 7'h05, 32'h0,  FL_E, 16'd0);
    addv(1, 0, 0, 0, 32'h0,  7'h05, 32'h4,  FL_F, 16'd1);
    addv(1, 0, 1, 1, 32'h80, 7'h05, 32'h4,  FL_F, 16'd1);
    addv(1, 0, 0, 0, 32'h0,  7'h05, 32'h4,  FL_E, 16'd1);
    addv(1, 0, 0, 1, 32'h22, 7'h05, 32'h20, FL_F, 16'd2);
    addv(1, 0, 0, 0, 32'h0,  7'h05, 32'h20, FL_F, 16'd2);
    addv(1, 0, 0, 0, 32'h0,  7'h05, 32'h20, FL_E, 16'd2);
    addv(1, 0, 1, 1, 32'h8,  7'h00, 32'h20, FL_H, 16'd2);
    addv(1, 0, 1, 1, 32'h0,  7'h03, 32'h20, FL_H, 16'd2);
    addv(1, 1, 0, 0, 32'h0,  7'h03, 32'h0,  FL_F, 16'd0);
    addv(1, 0, 0, 0, 32'h0,  7'h03, 32'h0,  FL_F, 16'd0);
    addv(0, 0, 0, 0, 32'h0,  7'h03, 32'h0,  FL_I, 16'd0);
    addv(1, 1, 0, 0, 32'h0,  7'h03, 32'h0,  FL_F, 16'd0);
    addv(1, 0, 0, 0, 32'h0,  7'h03, 32'h0,  FL_F, 16'd0);
    addv(1, 0, 0, 0, 32'h0,  7'h03, 32'h0,  FL_E, 16'd0);
    addv(0, 0, 0, 0, 32'h0,  7'h05, 32'h0,  FL_I, 16'd0);
    addv(1, 1, 0, 0, 32'h0,  7'h03, 32'h0,  FL_F, 16'd0);
    addv(1, 0, 0, 0, 32'h0,  7'h03, 32'h0,  FL_F, 16'd0);
    addv(1, 0, 0, 0, 32'h0,  7'h03, 32'h0,  FL_E, 16'd0);
    addv(1, 0, 0, 1, 32'h1,  7'h03, 32'h0,  FL_F, 16'd1);
    addv(1, 0, 0, 0, 32'h0,  7'h03, 32'h0,  FL_F, 16'd1);
    addv(1, 0, 0, 0, 32'h0,  7'h03, 32'h0,  FL_E, 16'd1);
    addv(1, 0, 0, 1, 32'h46, 7'h03, 32'h0,  FL_H, 16'd2);
    addv(1, 1, 0, 0, 32'h0,  7'h03, 32'h0,  FL_F, 16'd0);

    use_rom = 1'b0;
    vcnt = vecs.size();
    for (int i = 0; i < vcnt; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; stall = vecs[i].stall;
      branch_taken = vecs[i].br; branch_target = vecs[i].tgt; opcode_drv = vecs[i].op;
      tick();
      check_obs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fl, vecs[i].cnt);
      check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(fl_to_state(vecs[i].fl)));
    end

    // Straight-line program, then the same again restarted from HALT
    use_rom = 1'b1;
    fill_rom(1'b0);
    do_reset();
    run_linear("linear");
    run_linear("rerun");

    // NOP terminator at pc 12
    fill_rom(1'b0);
    rom[3] = OPCODE_NOP;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!halted && n < 60) begin tick(); n++; end
    check("nop_halted", 32'(halted), 32'd1);
    check("nop_pc", pc, 32'd12);
    check("nop_cnt", 32'(inst_count), 32'd3);
    tick();
    check("nop_pc_hold", pc, 32'd12);

    // Four-cycle stall at pc 8
    fill_rom(1'b0);
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(inst_valid && pc == 32'd8) && n < 40) begin tick(); n++; end
    check("stall_reach_pc8", 32'(inst_valid && pc == 32'd8), 32'd1);
    vcnt = inst_valid ? 1 : 0;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_valid) vcnt++;
      check($sformatf("stall_pc%0d", i), pc, 32'd8);
    end
    stall = 1'b0;
    tick();
    check("stall_valid_cycles", 32'(vcnt), 32'd5);
    check_obs("stall_after", 32'd12, FL_F, 16'd3);

    // Reset in the middle of fetching pc 20
    fill_rom(1'b0);
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(busy && !inst_valid && pc == 32'd20) && n < 60) begin tick(); n++; end
    check("rstmid_reach_pc20", 32'(busy && !inst_valid && pc == 32'd20), 32'd1);
    rst = 1'b0; tick(); rst = 1'b1;
    check_obs("rstmid_idle", 32'd0, FL_I, 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_obs("rstmid_restart", 32'd0, FL_F, 16'd0);
    tick(); tick();
    check_obs("rstmid_exec0", 32'd0, FL_E, 16'd0);

    // Random programs with random stalls, forward branches and noise inputs
    do_reset();
    for (int r = 0; r < NRUNS; r++) begin
      fill_rom(1'b1);
      build_run(ncyc);
      for (int c = 0; c < ncyc; c++) begin
        start = in_start[c]; stall = in_stall[c];
        branch_taken = in_br[c]; branch_target = in_tgt[c];
        tick();
        check_obs($sformatf("rnd%0d_c%0d", r, c), e_pc[c], e_fl[c], e_cnt[c]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
